valid_delay_line: RTL
=====================

// Module: valid_delay_line
// PURPOSE
//  Runtime-programmable, stallable delay line. It carries a valid bit with every data word.
//  It is the successor to the fixed-depth multicycle delay register in MCycle.
//  It aligns operands and results for multicycle units whose latency depends on the op, and
//  supports a stall (i_en), a flush (i_flush) and occupancy tracking.
// PARAMETERS
//  DATA_WIDTH     32  width of each data word
//  MAX_DEPTH      8   number of physical stages (>=1)
//  DEFAULT_DEPTH  4   tap depth after reset (0..MAX_DEPTH)
//  CW             $clog2(MAX_DEPTH+1)  width of depth/count fields (localparam)
// PORTS
//  i_clk       in   1           clock, rising edge
//  i_rst_n     in   1           asynchronous reset, active-low
//  i_en        in   1           advance enable; 0 = stall, all stages hold
//  i_flush     in   1           discard all in-flight items
//  i_valid     in   1           input word valid
//  i_data      in   DATA_WIDTH  input word
//  i_depth_ld  in   1           request to load a new tap depth
//  i_depth     in   CW          requested depth, 0..MAX_DEPTH
//  o_valid     out  1           output word emitted this cycle (exactly once per item)
//  o_data      out  DATA_WIDTH  output word
//  o_count     out  CW          valid items currently in stages 1..depth
//  o_empty     out  1           o_count==0
//  o_depth     out  CW          active tap depth
//  o_depth_err out  1           one-cycle pulse: depth load rejected or clamped
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - all stage valid bits = 0; o_count = 0; o_depth = DEFAULT_DEPTH; o_depth_err = 0.
//  Stage k (1..MAX_DEPTH) = {v_k, d_k}.
//   - On an edge with i_en=1 and i_flush=0: s1 <= {i_valid, i_data} and s_k <= s_(k-1).
//   - With i_en=0, every stage holds.
//  Output, with D = o_depth:
//   - D==0: combinational pass-through. o_valid = i_valid & i_en & ~i_flush; o_data = i_data.
//   - D>0: o_valid = v_D & i_en & ~i_flush; o_data = d_D.
//   - Latency is exactly D enabled cycles. Stall cycles add to the wall-clock latency.
//   - Stages beyond D still shift, but they are never observed.
//  Flush:
//   - Has priority over i_en. The next edge clears every v_k and sets o_count = 0.
//   - The input word presented in the flush cycle is dropped; o_valid = 0 in that cycle.
//  Count (D>0):
//   - +1 when i_en & i_valid & ~i_flush.
//   - -1 when o_valid.
//   - Both in the same cycle: unchanged.
//   - It cannot overflow, because at most D items fit.
//   - D==0: count stays 0.
//  Depth load (sampled on the edge where i_depth_ld=1):
//   - Accepted only if (o_empty & ~(i_valid&i_en)) | i_flush.
//   - Accepted: o_depth <= i_depth, and all v_k are cleared so stale beyond-tap items are purged.
//   - i_depth > MAX_DEPTH: the load is accepted, o_depth <= MAX_DEPTH, and o_depth_err pulses.
//   - Not accepted: o_depth is unchanged and o_depth_err pulses for one cycle. No other effect.
//  o_depth_err is registered. It is 1 for exactly the cycle after the offending request.
//  Data registers carry no reset; only valid bits and control state are reset.
//   - Exception: when VDL_DATA_CLEAR_EN is defined (see CONFIGURATION).
//  Reset asserted mid-operation: all in-flight items are lost immediately; no o_valid is produced.
// CONFIGURATION
//  VDL_DATA_CLEAR_EN
//   - Defined: every d_k has async reset to 0 and is zeroed by flush.
//     In any cycle with o_valid=0, o_data is forced to 0 (deterministic bus, lower toggling).
//   - Undefined: d_k has no reset and is not cleared. o_data shows the raw tap contents when o_valid=0.
//     This is the smaller area option.
//   - o_valid, o_count and o_depth behave identically in both builds.
// TESTING
//  1. Reset then D=4, i_en=1, inputs A1..A6 on consecutive cycles -> A1 appears on o_valid 4 cycles later, then A2..A6 in order; o_count peaks at 4.
//  2. D=3, A1 in, stall i_en=0 for 2 cycles after cycle 1 -> A1 emitted after 5 cycles; o_valid is never 1 while i_en=0.
//  3. D=5, 3 items in flight, i_flush=1 with i_valid=1 -> next cycle o_count=0; no further o_valid; the flushed input is never emitted.
//  4. D=2 with 1 item in flight, i_depth_ld=1, i_depth=6 -> rejected, o_depth_err=1 for one cycle, o_depth stays 2, item still emitted.
//  5. Empty, i_depth_ld=1, i_depth=15 (MAX_DEPTH=8) -> o_depth=8 and o_depth_err pulses. Then i_depth=0 load: pass-through, o_data==i_data in the same cycle.
//  6. Both builds: 4 items in flight at D=4, i_rst_n pulsed low mid-stream -> o_valid=0, o_count=0, o_depth=DEFAULT_DEPTH. With VDL_DATA_CLEAR_EN, o_data==0.

Source files
------------

// File: rtl/valid_delay_line.sv
// Runtime-programmable, stallable delay line that carries a valid bit with every data word.
// Optional build macro: VDL_DATA_CLEAR_EN (zeroes data stages on reset and flush, and drives o_data to 0 when idle).
module valid_delay_line #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_DEPTH     = 8,
    parameter int DEFAULT_DEPTH = 4,
    localparam int CW           = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_depth_ld,
    input  logic [CW-1:0]         i_depth,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CW-1:0]         o_count,
    output logic                  o_empty,
    output logic [CW-1:0]         o_depth,
    output logic                  o_depth_err
);

    logic                  r_valid [1:MAX_DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [1:MAX_DEPTH];
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_depth;
    logic                  r_depth_err;

    logic                  w_shift;
    logic                  w_in_fire;
    logic                  w_tap_valid;
    logic [DATA_WIDTH-1:0] w_tap_data;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_depth_ok;
    logic                  w_depth_acc;
    logic                  w_depth_big;
    logic [CW-1:0]         w_depth_next;

    assign w_shift   = i_en & ~i_flush;
    assign w_in_fire = w_shift & i_valid;

    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (r_depth == CW'(k)) begin
                w_tap_valid = r_valid[k];
                w_tap_data  = r_data[k];
            end
        end
    end

    // Depth 0 bypasses the stages entirely and behaves as a wire.
    assign w_out_valid = (r_depth == '0) ? w_in_fire : (w_tap_valid & w_shift);
    assign w_out_data  = (r_depth == '0) ? i_data : w_tap_data;

`ifdef VDL_DATA_CLEAR_EN
    assign o_data = w_out_valid ? w_out_data : '0;
`else
    assign o_data = w_out_data;
`endif

    assign o_valid     = w_out_valid;
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_depth     = r_depth;
    assign o_depth_err = r_depth_err;

    // A depth change is only safe with nothing in flight, or when a flush discards everything anyway.
    assign w_depth_ok   = (o_empty & ~(i_valid & i_en)) | i_flush;
    assign w_depth_acc  = i_depth_ld & w_depth_ok;
    assign w_depth_big  = (i_depth > CW'(MAX_DEPTH));
    assign w_depth_next = w_depth_big ? CW'(MAX_DEPTH) : i_depth;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (i_flush || w_depth_acc) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (i_en) begin
            r_valid[1] <= i_valid;
            for (int k = 2; k <= MAX_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

`ifdef VDL_DATA_CLEAR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (i_flush) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (i_en) begin
            r_data[1] <= i_data;
            for (int k = 2; k <= MAX_DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (w_shift) begin
            r_data[1] <= i_data;
            for (int k = 2; k <= MAX_DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_flush || w_depth_acc) begin
            r_count <= '0;
        end else if (r_depth != '0) begin
            if (w_in_fire && !w_out_valid) begin
                r_count <= r_count + CW'(1);
            end else if (!w_in_fire && w_out_valid) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth     <= CW'(DEFAULT_DEPTH);
            r_depth_err <= 1'b0;
        end else begin
            r_depth_err <= i_depth_ld & (~w_depth_ok | w_depth_big);
            if (w_depth_acc) begin
                r_depth <= w_depth_next;
            end
        end
    end

endmodule
